debounce_multi: RTL and testbench

- N-channel successor to the single-button debouncer, for front-panel button banks.
- Each channel synchronises and debounces its input and reports a stable level plus one-cycle press and release pulses.
- Adds long-press detection and optional auto-repeat while a button is held.
- All timing runs on a shared 1 ms tick, so per-channel counters stay narrow. Sits between board pins and UI/control FSMs.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/ms_tick.sv | 27 ++
 rtl/debounce_multi.sv | 151 +++++++++++++++
 tb/tb_debounce_multi.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and width/period derivations for the multi-channel button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_e;

  localparam int unsigned MS_PER_S = 1000;

  function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
    return clk_hz / MS_PER_S;
  endfunction

  function automatic int unsigned presc_w(input int unsigned clk_hz);
    return $clog2(clk_hz / MS_PER_S);
  endfunction

  function automatic int unsigned deb_w(input int unsigned deb_ms);
    return $clog2(deb_ms + 1);
  endfunction

  function automatic int unsigned hold_w(input int unsigned long_ms, input int unsigned rep_ms);
    return $clog2(((long_ms > rep_ms) ? long_ms : rep_ms) + 1);
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running 1 ms strobe shared by all debounce channels.
module ms_tick
  import debounce_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CPM = cycles_per_ms(CLK_HZ);
  localparam int unsigned PW  = presc_w(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(CPM - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/debounce_multi.sv
// N-channel button debouncer: synchronise, debounce on a 1 ms tick, then
// report level, press/release pulses, long-press and auto-repeat per channel.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CLK_HZ      = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam int unsigned DW = deb_w(DEBOUNCE_MS);
  localparam int unsigned HW = hold_w(LONG_MS, REPEAT_MS);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_MS - 1);
  localparam logic          REP_ON    = (REPEAT_EN != 0);

  logic            tick;
  logic [N_CH-1:0] norm, sync1_q, sync2_q;

  ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign norm = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= norm;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          stable_q, stable_d;
    hold_state_e   state_q, state_d;
    logic          press_q, press_d, rel_q, rel_d, long_q, long_d, rep_q, rep_d;
    logic          rise, fall;

    always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = deb_cnt_q;
      if (sync2_q[g] == stable_q) begin
        deb_cnt_d = '0;
      end else if (tick) begin
        if (deb_cnt_q == DEB_LAST) begin
          stable_d  = sync2_q[g];
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end

    // Edges are taken from the accepting decision so a fall that lands on a
    // threshold tick suppresses that long/repeat pulse.
    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;
      long_d     = 1'b0;
      rep_d      = 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          press_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = HELD;
        end
        HELD: if (fall) begin
          rel_d      = 1'b1;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (tick) begin
          if (hold_cnt_q == LONG_LAST) begin
            long_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = LONG;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        LONG: if (fall) begin
          rel_d      = 1'b1;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (tick) begin
          if (hold_cnt_q == REP_LAST) begin
            rep_d      = REP_ON;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        stable_q   <= 1'b0;
        state_q    <= IDLE;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
        long_q     <= 1'b0;
        rep_q      <= 1'b0;
      end else begin
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        stable_q   <= stable_d;
        state_q    <= state_d;
        press_q    <= press_d;
        rel_q      <= rel_d;
        long_q     <= long_d;
        rep_q      <= rep_d;
      end
    end

    assign level_o[g]      = stable_q;
    assign press_o[g]      = press_q;
    assign release_o[g]    = rel_q;
    assign long_press_o[g] = long_q;
    assign repeat_o[g]     = rep_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: 2 channels, 10 cycles/ms, debounce 3 ms,
// long 20 ms, repeat 5 ms; a second instance has auto-repeat disabled.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] lvl, prs, rel, lng, rep;
  logic [1:0] lvl_n, prs_n, rel_n, lng_n, rep_n;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(2), .CLK_HZ(10_000), .DEBOUNCE_MS(3), .LONG_MS(20),
    .REPEAT_MS(5), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .level_o(lvl), .press_o(prs),
    .release_o(rel), .long_press_o(lng), .repeat_o(rep)
  );

  debounce_multi #(
    .N_CH(2), .CLK_HZ(10_000), .DEBOUNCE_MS(3), .LONG_MS(20),
    .REPEAT_MS(5), .REPEAT_EN(0), .ACTIVE_LOW(1)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .level_o(lvl_n), .press_o(prs_n),
    .release_o(rel_n), .long_press_o(lng_n), .repeat_o(rep_n)
  );

  // Event monitor: counts pulses and remembers when they happened.
  int cyc = 0;
  int n_press[2] = '{default: 0};
  int n_rel[2]   = '{default: 0};
  int n_long[2]  = '{default: 0};
  int n_rep[2]   = '{default: 0};
  int t_press[2] = '{default: 0};
  int t_rel[2]   = '{default: 0};
  int t_long[2]  = '{default: 0};
  int t_rep[2]   = '{default: 0};
  int t_rep_prev[2] = '{default: 0};
  int n_rep_nr = 0;
  int n_long_nr = 0;
  int viol = 0;
  logic [1:0] prs_p = '0, rel_p = '0, lng_p = '0, rep_p = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (prs[c] === 1'b1) begin n_press[c]++; t_press[c] = cyc; end
      if (rel[c] === 1'b1) begin n_rel[c]++;   t_rel[c]   = cyc; end
      if (lng[c] === 1'b1) begin n_long[c]++;  t_long[c]  = cyc; end
      if (rep[c] === 1'b1) begin n_rep[c]++; t_rep_prev[c] = t_rep[c]; t_rep[c] = cyc; end
      if (int'(prs[c]) + int'(rel[c]) + int'(lng[c]) + int'(rep[c]) > 1) viol++;
      if ((prs[c] & prs_p[c]) | (rel[c] & rel_p[c]) | (lng[c] & lng_p[c]) | (rep[c] & rep_p[c])) viol++;
    end
    if (rep_n != 2'b00) n_rep_nr++;
    if (lng_n != 2'b00) n_long_nr++;
    prs_p = prs; rel_p = rel; lng_p = lng; rep_p = rep;
  end

  int n_chk = 0;
  int n_fail = 0;
  int sp[2], sr[2], sl[2], sq[2];
  int s_rep_nr, s_long_nr;
  int t0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    sp = n_press; sr = n_rel; sl = n_long; sq = n_rep;
    s_rep_nr = n_rep_nr; s_long_nr = n_long_nr;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int all_outs();
    return int'({lvl, prs, rel, lng, rep, lvl_n, prs_n, rel_n, lng_n, rep_n});
  endfunction

  initial begin
    rst_n = 1'b0;
    btn   = 2'b11;
    step(3);
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    step(1);
    check("post_reset_outs", all_outs(), 0);
    step(20);

    // 1: clean press and release on channel 0
    snap();
    btn[0] = 1'b0; t0 = cyc;
    step(40);
    check("t1_press_cnt", n_press[0] - sp[0], 1);
    check_rng("t1_press_lat", t_press[0] - t0 - 1, 21, 33);
    check("t1_level", int'(lvl), 1);
    check("t1_ch1_quiet", n_press[1] - sp[1], 0);
    check("t1_no_long", n_long[0] - sl[0], 0);
    btn[0] = 1'b1; t0 = cyc;
    step(40);
    check("t1_rel_cnt", n_rel[0] - sr[0], 1);
    check_rng("t1_rel_lat", t_rel[0] - t0 - 1, 21, 33);
    check("t1_level_off", int'(lvl), 0);

    // 2: bouncing contact, then settles pressed
    snap();
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      step(15);
    end
    check("t2_no_press_bounce", n_press[0] - sp[0], 0);
    btn[0] = 1'b0; t0 = cyc;
    step(40);
    check("t2_press_cnt", n_press[0] - sp[0], 1);
    check_rng("t2_press_lat", t_press[0] - t0 - 1, 21, 33);
    check("t2_no_rel", n_rel[0] - sr[0], 0);
    btn[0] = 1'b1;
    step(40);

    // 3: long press and auto-repeat on channel 1, release between repeats
    snap();
    btn[1] = 1'b0; t0 = cyc;
    step(370);
    btn[1] = 1'b1;
    step(60);
    check("t3_press_cnt", n_press[1] - sp[1], 1);
    check("t3_long_cnt", n_long[1] - sl[1], 1);
    check("t3_long_dly", t_long[1] - t_press[1], 200);
    check("t3_rep_cnt", n_rep[1] - sq[1], 3);
    check("t3_rep_period", t_rep[1] - t_rep_prev[1], 50);
    check("t3_last_rep", t_rep[1] - t_long[1], 150);
    check("t3_rel_cnt", n_rel[1] - sr[1], 1);
    check("t3_rel_dly", t_rel[1] - t_long[1], 170);
    check("t3_ch0_quiet", n_press[0] - sp[0], 0);
    check("t3_nr_no_rep", n_rep_nr - s_rep_nr, 0);
    check("t3_nr_long", n_long_nr - s_long_nr, 1);

    // 4: short glitch is ignored
    snap();
    btn[0] = 1'b0;
    step(15);
    btn[0] = 1'b1;
    step(50);
    check("t4_no_press", n_press[0] - sp[0], 0);
    check("t4_no_rel", n_rel[0] - sr[0], 0);
    check("t4_level", int'(lvl), 0);

    // 5: release accepted on the long-threshold tick
    snap();
    btn[1] = 1'b0;
    step(200);
    btn[1] = 1'b1;
    step(60);
    check("t5_press_cnt", n_press[1] - sp[1], 1);
    check("t5_no_long", n_long[1] - sl[1], 0);
    check("t5_rel_cnt", n_rel[1] - sr[1], 1);
    check("t5_rel_dly", t_rel[1] - t_press[1], 200);
    check("t5_nr_no_long", n_long_nr - s_long_nr, 0);

    // 6: reset in the middle of a long hold
    btn[0] = 1'b0;
    step(250);
    check("t6_level_before", int'(lvl), 1);
    snap();
    rst_n = 1'b0;
    #1;
    check("t6_reset_outs", all_outs(), 0);
    step(3);
    rst_n = 1'b1; t0 = cyc;
    step(1);
    check("t6_post_reset_outs", all_outs(), 0);
    step(40);
    check("t6_press_cnt", n_press[0] - sp[0], 1);
    check_rng("t6_press_lat", t_press[0] - t0 - 1, 21, 33);
    check("t6_no_rel", n_rel[0] - sr[0], 0);
    btn[0] = 1'b1;
    step(40);
    check("t6_rel_cnt", n_rel[0] - sr[0], 1);

    check("pulse_rules", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
